// File: rtl/clk_gate_pkg.sv
// Shared types and sizing helpers for the multi-channel clock-gating controller.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_DRAIN = 2'd1,
    CG_OFF   = 2'd2,
    CG_WAKE  = 2'd3
  } cg_state_e;

  localparam int unsigned HS_TIMEOUT_DFLT = 64;
  localparam int unsigned TO_W            = $clog2(HS_TIMEOUT_DFLT);

  // Timeout counter only has to hold HS_TIMEOUT-1; keep at least one bit.
  function automatic int unsigned cg_to_w(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/clk_gate_cell.sv
// Latch-based integrated clock gate. Behavioural stand-in for the library ICG:
// enable is captured while clk_in is low, so clk_out can never be truncated.
module clk_gate_cell (
  input  logic clk_in,
  input  logic en,
  input  logic test_mode,
  output logic clk_out
);

  logic en_lat;

  always_latch begin
    if (!clk_in) en_lat <= en | test_mode;
  end

  assign clk_out = clk_in & en_lat;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Per-channel gate/wake FSM with quiesce handshake, idle-based auto gating
// and sticky handshake-timeout status, driving one ICG cell per channel.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 8,
  parameter int unsigned IDLE_W     = 8,
  parameter int unsigned HS_TIMEOUT = HS_TIMEOUT_DFLT
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 test_mode,
  input  logic [NUM_PORTS-1:0] sw_en,
  input  logic [NUM_PORTS-1:0] auto_en,
  input  logic [NUM_PORTS-1:0] idle,
  input  logic [IDLE_W-1:0]    idle_thresh,
  output logic [NUM_PORTS-1:0] quiesce_req,
  input  logic [NUM_PORTS-1:0] quiesce_ack,
  output logic [NUM_PORTS-1:0] clk_out,
  output logic [NUM_PORTS-1:0] gated,
  output logic [NUM_PORTS-1:0] hs_err
);

  localparam int unsigned CNT_W = cg_to_w(HS_TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(HS_TIMEOUT - 1);

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ch
    cg_state_e         state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic [CNT_W-1:0]  to_cnt_q;
    logic              en_q;
    logic              hs_err_q;
    logic              idle_hit;
    logic              gate_cond;
    logic              wake_cond;
    logic              to_hit;
    logic              set_err;

    assign idle_hit  = auto_en[g] & idle[g] & (idle_cnt_q >= idle_thresh);
    assign gate_cond = ~sw_en[g] | idle_hit;
    assign wake_cond = sw_en[g] & ~(auto_en[g] & idle[g]);
    assign to_hit    = (to_cnt_q == TO_LAST);

    always_comb begin
      state_d = state_q;
      set_err = 1'b0;
      unique case (state_q)
        CG_RUN: begin
          if (gate_cond) state_d = CG_DRAIN;
        end
        CG_DRAIN: begin
          // Ack has priority over a concurrent wake; the wake is taken from OFF.
          if (quiesce_ack[g]) begin
            state_d = CG_OFF;
          end else if (wake_cond) begin
            state_d = CG_WAKE;
          end else if (to_hit) begin
            state_d = CG_WAKE;
            set_err = 1'b1;
          end
        end
        CG_OFF: begin
          if (wake_cond) state_d = CG_WAKE;
        end
        CG_WAKE: begin
          if (!quiesce_ack[g]) begin
            state_d = CG_RUN;
          end else if (to_hit) begin
            state_d = CG_RUN;
            set_err = 1'b1;
          end
        end
        default: state_d = CG_RUN;
      endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        state_q  <= CG_RUN;
        en_q     <= 1'b1;
        hs_err_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        en_q     <= (state_d != CG_OFF);
        hs_err_q <= hs_err_q | set_err;
      end
    end

    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        idle_cnt_q <= '0;
      end else if ((state_q != CG_RUN) || !idle[g]) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != '1) begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end
    end

    // Restarts on every state change, so each handshake phase gets a full budget.
    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        to_cnt_q <= '0;
      end else if ((state_d != state_q) ||
                   !((state_q == CG_DRAIN) || (state_q == CG_WAKE))) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end

    assign quiesce_req[g] = (state_q == CG_DRAIN) || (state_q == CG_OFF);
    assign gated[g]       = (state_q == CG_OFF);
    assign hs_err[g]      = hs_err_q;

    clk_gate_cell u_cell (
      .clk_in    (clk_in),
      .en        (en_q),
      .test_mode (test_mode),
      .clk_out   (clk_out[g])
    );
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed self-checking bench for clk_gate_ctrl: gating, wake, idle auto
// gating, handshake timeout, test-mode override and mid-operation reset.
`timescale 1ns/1ps
module tb_clk_gate_ctrl;

  localparam int unsigned NP = 8;

  logic          clk_in;
  logic          rst;
  logic          test_mode;
  logic [NP-1:0] sw_en;
  logic [NP-1:0] auto_en;
  logic [NP-1:0] idle;
  logic [7:0]    idle_thresh;
  logic [NP-1:0] quiesce_req;
  logic [NP-1:0] quiesce_ack;
  logic [NP-1:0] clk_out;
  logic [NP-1:0] gated;
  logic [NP-1:0] hs_err;

  logic [NP-1:0] ack_drv;
  logic [NP-1:0] ack_tie;

  int checks   = 0;
  int failures = 0;

  time  t_rise = 0;
  time  min_hi = 1000;
  logic trk    = 1'b0;
  logic run_ok;

  assign quiesce_ack = (ack_drv & ~ack_tie) | (quiesce_req & ack_tie);

  clk_gate_ctrl #(
    .NUM_PORTS  (8),
    .IDLE_W     (8),
    .HS_TIMEOUT (64)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .test_mode   (test_mode),
    .sw_en       (sw_en),
    .auto_en     (auto_en),
    .idle        (idle),
    .idle_thresh (idle_thresh),
    .quiesce_req (quiesce_req),
    .quiesce_ack (quiesce_ack),
    .clk_out     (clk_out),
    .gated       (gated),
    .hs_err      (hs_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_out[2]) t_rise = $time;
  always @(negedge clk_out[2]) begin
    if (trk && (($time - t_rise) < min_hi)) min_hi = $time - t_rise;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1ns into the high phase, where clk_out shows the gate state.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    test_mode   = 1'b0;
    sw_en       = '1;
    auto_en     = '0;
    idle        = '0;
    idle_thresh = 8'd0;
    ack_drv     = '0;
    ack_tie     = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    // 1: reset state, all clocks running
    check_eq("rst_gated",  32'(gated),       32'h00);
    check_eq("rst_qreq",   32'(quiesce_req), 32'h00);
    check_eq("rst_hs_err", 32'(hs_err),      32'h00);
    check_eq("rst_clk",    32'(clk_out),     32'hFF);

    // 2: ch0 software gate then wake
    sw_en[0] = 1'b0;
    tick();
    check_eq("c0_qreq_drain",   32'(quiesce_req[0]), 32'h1);
    check_eq("c0_clk_in_drain", 32'(clk_out[0]),     32'h1);
    repeat (2) tick();
    check_eq("c0_still_drain",  32'({quiesce_req[0], gated[0]}), 32'h2);
    ack_drv[0] = 1'b1;
    tick();
    check_eq("c0_gated",        32'(gated[0]),   32'h1);
    check_eq("c0_last_pulse",   32'(clk_out[0]), 32'h1);
    tick();
    check_eq("c0_clk_stopped",  32'(clk_out[0]), 32'h0);
    repeat (3) tick();
    check_eq("c0_clk_flat",     32'(clk_out[0]),   32'h0);
    check_eq("c0_others_run",   32'(clk_out[7:1]), 32'h7F);
    sw_en[0] = 1'b1;
    tick();
    check_eq("c0_wake_status",  32'({quiesce_req[0], gated[0]}), 32'h0);
    check_eq("c0_wake_clk_off", 32'(clk_out[0]), 32'h0);
    tick();
    check_eq("c0_clk_resumed",  32'(clk_out[0]), 32'h1);
    ack_drv[0] = 1'b0;
    tick();
    sw_en[0] = 1'b0;
    tick();
    check_eq("c0_run_regate",   32'(quiesce_req[0]), 32'h1);
    sw_en[0] = 1'b1;
    repeat (2) tick();
    check_eq("c0_back_run",     32'(quiesce_req[0]), 32'h0);

    // 3: ch3 idle-based auto gating, threshold 5, ack follows request
    auto_en[3]  = 1'b1;
    idle_thresh = 8'd5;
    ack_tie[3]  = 1'b1;
    idle[3]     = 1'b1;
    repeat (3) tick();
    idle[3] = 1'b0;
    tick();
    idle[3] = 1'b1;
    repeat (5) tick();
    check_eq("c3_no_gate_early", 32'(quiesce_req[3]), 32'h0);
    tick();
    check_eq("c3_drain_at_thr",  32'({quiesce_req[3], gated[3]}), 32'h2);
    tick();
    check_eq("c3_off",           32'(gated[3]), 32'h1);
    tick();
    check_eq("c3_clk_stopped",   32'(clk_out[3]), 32'h0);
    idle[3] = 1'b0;
    tick();
    check_eq("c3_wake",          32'({quiesce_req[3], gated[3]}), 32'h0);
    tick();
    check_eq("c3_clk_back",      32'(clk_out[3]), 32'h1);
    auto_en[3] = 1'b0;
    ack_tie[3] = 1'b0;

    // 4: ch1 handshake timeout, no ack ever
    run_ok   = 1'b1;
    sw_en[1] = 1'b0;
    tick();
    check_eq("c1_drain", 32'(quiesce_req[1]), 32'h1);
    for (int i = 0; i < 63; i++) begin
      tick();
      run_ok &= clk_out[1];
    end
    check_eq("c1_no_err_yet", 32'(hs_err),         32'h00);
    check_eq("c1_still_req",  32'(quiesce_req[1]), 32'h1);
    tick();
    check_eq("c1_hs_err",     32'(hs_err),         32'h02);
    check_eq("c1_wake_req",   32'(quiesce_req[1]), 32'h0);
    sw_en[1] = 1'b1;
    repeat (2) tick();
    run_ok &= clk_out[1];
    check_eq("c1_clk_never_stop", 32'(run_ok), 32'h1);
    check_eq("c1_err_sticky",     32'(hs_err), 32'h02);

    // 5: ch2 gated, test_mode override, then clean stop
    sw_en[2]   = 1'b0;
    ack_drv[2] = 1'b1;
    repeat (3) tick();
    check_eq("c2_off_clk",   32'({gated[2], clk_out[2]}), 32'h2);
    trk       = 1'b1;
    test_mode = 1'b1;
    tick();
    check_eq("c2_tm_clk",    32'({gated[2], clk_out[2]}), 32'h3);
    repeat (2) tick();
    check_eq("tm_all_clk",   32'(clk_out), 32'hFF);
    test_mode = 1'b0;
    tick();
    check_eq("c2_tm_off",    32'(clk_out[2]), 32'h0);
    tick();
    trk = 1'b0;
    check_eq("c2_min_high",  32'(min_hi), 32'd5);
    check_eq("c2_still_off", 32'(gated[2]), 32'h1);

    // 6: ch5 gated, then reset mid-operation
    sw_en[5]   = 1'b0;
    ack_drv[5] = 1'b1;
    repeat (3) tick();
    check_eq("pre_rst_clk",   32'(clk_out), 32'hDB);
    check_eq("pre_rst_gated", 32'(gated),   32'h24);
    rst = 1'b1;
    #1;
    check_eq("rst_async_qreq",  32'(quiesce_req), 32'h00);
    check_eq("rst_async_gated", 32'(gated),       32'h00);
    check_eq("rst_no_runt",     32'(clk_out[5]),  32'h0);
    sw_en   = '1;
    ack_drv = '0;
    tick();
    check_eq("rst_clk_resume",  32'(clk_out), 32'hFF);
    check_eq("rst_hs_err_clr",  32'(hs_err),  32'h00);
    rst = 1'b0;
    repeat (3) tick();
    check_eq("post_rst_clk",    32'(clk_out),     32'hFF);
    check_eq("post_rst_qreq",   32'(quiesce_req), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
Multi-channel clock-gating controller. Each of NUM_PORTS channels gets a glitch-free gated copy of clk_in, built from a latch-based ICG cell. Each channel has its own FSM that gates the clock on software request or after a programmable idle period. Gating and waking use a quiesce handshake with the client. Sits in the clock/power-management fabric between the top clock root and per-subsystem clock domains.

Parameters:
NUM_PORTS, 8, number of independently gated channels (1..32)
IDLE_W, 8, width of the idle-threshold field and each channel's idle counter
HS_TIMEOUT, 64, max cycles to wait for quiesce_ack before aborting a gate attempt (≥2)

Ports:
clk_in  input  1  source clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
test_mode  input  1  scan/test override; forces every clk_out to follow clk_in
sw_en  input  NUM_PORTS  per-channel software clock enable (1 = clock wanted)
auto_en  input  NUM_PORTS  per-channel enable for idle-based auto gating
idle  input  NUM_PORTS  per-channel idle indication from client, synchronous to clk_in
idle_thresh  input  IDLE_W  shared idle threshold in cycles
quiesce_req  output  NUM_PORTS  request to client to quiesce (gate) / held while gated
quiesce_ack  input  NUM_PORTS  client acknowledgement, level, synchronous to clk_in
clk_out  output  NUM_PORTS  gated clocks
gated  output  NUM_PORTS  status, 1 while channel clock is stopped
hs_err  output  NUM_PORTS  sticky; set on handshake timeout, cleared only by rst

Behaviour:
- Reset (async assert, sync release): all FSMs in RUN; en_q=1 (clocks running); quiesce_req=0, gated=0, hs_err=0; idle counters 0, timeout counters 0.
- Idle counter per channel: increments while idle=1, cleared when idle=0 or state≠RUN, saturates at 2^IDLE_W-1.
- Idle condition: auto_en & idle & (cnt ≥ idle_thresh). idle_thresh=0 means idle alone qualifies.
- gate_cond = !sw_en | idle condition. wake_cond = sw_en & !(auto_en & idle).
- FSM per channel; all transitions registered; outputs come from state:
  - RUN: en_q=1, quiesce_req=0. If gate_cond, go to DRAIN.
  - DRAIN: quiesce_req=1, en_q=1, timeout counter runs.
    - quiesce_ack=1: go to OFF.
    - wake_cond (gate reason gone) with no ack: go to WAKE.
    - Counter reaches HS_TIMEOUT-1: set hs_err and go to WAKE.
  - OFF: en_q=0, gated=1, quiesce_req=1. If wake_cond, go to WAKE.
  - WAKE: en_q=1, gated=0, quiesce_req=0. Wait for quiesce_ack=0, then go to RUN. Timeout counter runs; on HS_TIMEOUT set hs_err and go to RUN.
- Latency: gate_cond sampled at edge N → quiesce_req high after edge N. Ack seen at edge M → en_q low after edge M; first suppressed clk_out high pulse is cycle M+1. Wake is symmetric, with clk_out resuming at cycle W+1.
- Simultaneous ack and wake_cond in DRAIN: ack wins (go to OFF); wake is then taken from OFF on the next cycle.
- ICG cell: level latch, transparent while clk_in=0, capturing en_q|test_mode; clk_out = clk_in & latched enable. No glitches or truncated high phases.
- test_mode=1: all clk_out follow clk_in. FSMs, handshakes and status run unchanged; gated reports FSM state, not the actual clock.
- rst mid-operation: a channel in OFF returns to RUN immediately. Its clock restarts on the next low phase of clk_in, and quiesce_req drops asynchronously.
- Channels are fully independent. Identical stimulus on all channels yields identical timing.

Decomposition:
- Package clk_gate_pkg: FSM enum cg_state_e {CG_RUN, CG_DRAIN, CG_OFF, CG_WAKE}; localparam TO_W = $clog2(HS_TIMEOUT).
- Sub-module clk_gate_cell: latch ICG (clk_in, en, test_mode → clk_out), with an isolated behavioural model that maps to the library ICG cell.
- Top instantiates NUM_PORTS copies of FSM + counters via generate, plus one clk_gate_cell per channel.

Test Plan:
1. Reset with sw_en=all-1 → clk_out toggles on all channels; gated=0, quiesce_req=0, hs_err=0.
2. Ch0: sw_en 1→0 at cycle 10, ack returned at cycle 13 → quiesce_req[0] high from cycle 11; clk_out[0] flat from cycle 14; gated[0]=1. Then sw_en=1 at cycle 30 and ack dropped at cycle 32 → clk_out[0] toggles from cycle 31; RUN by cycle 33.
3. Ch3: auto_en=1, idle_thresh=5, idle held high, ack tied to quiesce_req → DRAIN entered exactly 5 cycles after idle rises. idle pulsed low at cycle 3 → counter restarts and no gating occurs.
4. Ch1: no ack, HS_TIMEOUT=64 → hs_err[1]=1 after 64 cycles in DRAIN; channel returns through WAKE to RUN; clock never stops.
5. test_mode=1 with ch2 in OFF → clk_out[2] toggles while gated[2] stays 1. test_mode=0 → clock stops without runt pulses (check minimum high width equals clk_in high width).
6. Assert rst while ch5 is OFF → clk_out[5] resumes on the first clk_in low phase after rst; all status returns to reset values. Other channels remain unaffected during the test.
